// File: rtl/seq_pattern_detector_pkg.sv
// Shared constants for the serial pattern detector: output-timing and overlap
// mode selectors, plus the width of the fill counter.
package seq_det_pkg;

  localparam int MODE_MEALY = 1;
  localparam int MODE_MOORE = 0;
  localparam int OVL_ON     = 1;
  localparam int OVL_OFF    = 0;

  // fill only has to reach PAT_W-1, so clog2(PAT_W) bits are enough (min 1)
  function automatic int fill_w(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter. The sat flag is registered from the next count, so it
// rises in the same cycle the count reaches all ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;
  logic         r_sat;

  always_comb begin
    w_next = r_count;
    if (inc && !(&r_count)) w_next = r_count + W'(1);
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_sat   <= &w_next;
    end
  end

  assign count = r_count;
  assign sat   = r_sat;

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable serial pattern detector: history shift register, fill counter
// and match logic, with Mealy/Moore output timing and a saturating match count.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               MEALY   = MODE_MEALY,
  parameter int               OVERLAP = OVL_ON,
  parameter int               CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             x_valid,
  input  logic             x_in,
  output logic             y_out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int            FW       = fill_w(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-2:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic [PAT_W-1:0] w_shift;
  logic             w_clr;
  logic             w_hit;

  assign w_clr   = reset | clear;
  assign w_shift = {r_hist, x_in};
  // a bit arriving under reset/clear is discarded, so it can never complete a match
  assign w_hit   = x_valid & ~w_clr & (w_shift == PATTERN) & (r_fill == FILL_MAX);

  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (x_valid) begin
      r_hist <= w_shift[PAT_W-2:0];
      if (w_hit && OVERLAP == OVL_OFF) r_fill <= '0;
      else if (r_fill != FILL_MAX)     r_fill <= r_fill + FW'(1);
    end
  end

  generate
    if (MEALY == MODE_MEALY) begin : g_mealy
      assign y_out = w_hit;
    end else begin : g_moore
      logic r_y;
      always_ff @(posedge clock) begin
        if (w_clr) r_y <= 1'b0;
        else       r_y <= w_hit;
      end
      assign y_out = r_y;
    end
  endgenerate

  sat_counter #(.W(CNT_W)) u_cnt (
    .clock (clock),
    .clr   (w_clr),
    .inc   (w_hit),
    .count (match_count),
    .sat   (count_sat)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench: four detector configurations share one stimulus stream and
// each scenario task checks the instances it concerns.
module tb_seq_pattern_detector;
  import seq_det_pkg::*;

  localparam int PAT_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic x_valid = 1'b0;
  logic x_in = 1'b0;

  logic       y_mo, y_mn, y_ro, y_sat;
  logic [7:0] c_mo, c_mn, c_ro;
  logic [1:0] c_sat;
  logic       s_mo, s_mn, s_ro, s_sat;

  logic s_y_mo, s_y_mn, s_y_sat;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  initial assert (PAT_W >= 2) else $error("PAT_W must be at least 2");

  seq_pattern_detector #(.PAT_W(PAT_W), .PATTERN(4'b1101), .MEALY(MODE_MEALY),
                         .OVERLAP(OVL_ON), .CNT_W(8)) u_mo (
    .clock(clock), .reset(reset), .clear(clear), .x_valid(x_valid), .x_in(x_in),
    .y_out(y_mo), .match_count(c_mo), .count_sat(s_mo));

  seq_pattern_detector #(.PAT_W(PAT_W), .PATTERN(4'b1101), .MEALY(MODE_MEALY),
                         .OVERLAP(OVL_OFF), .CNT_W(8)) u_mn (
    .clock(clock), .reset(reset), .clear(clear), .x_valid(x_valid), .x_in(x_in),
    .y_out(y_mn), .match_count(c_mn), .count_sat(s_mn));

  seq_pattern_detector #(.PAT_W(PAT_W), .PATTERN(4'b1101), .MEALY(MODE_MOORE),
                         .OVERLAP(OVL_ON), .CNT_W(8)) u_ro (
    .clock(clock), .reset(reset), .clear(clear), .x_valid(x_valid), .x_in(x_in),
    .y_out(y_ro), .match_count(c_ro), .count_sat(s_ro));

  seq_pattern_detector #(.PAT_W(PAT_W), .PATTERN(4'b1101), .MEALY(MODE_MEALY),
                         .OVERLAP(OVL_OFF), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .clear(clear), .x_valid(x_valid), .x_in(x_in),
    .y_out(y_sat), .match_count(c_sat), .count_sat(s_sat));

  // one cycle: inputs change on negedge, Mealy outputs captured before the
  // rising edge, registered outputs readable on return (#1 after the edge)
  task automatic drive(input logic rst, input logic clr, input logic v, input logic x);
    @(negedge clock);
    reset = rst; clear = clr; x_valid = v; x_in = x;
    #2;
    s_y_mo = y_mo; s_y_mn = y_mn; s_y_sat = y_sat;
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      total++;
      if (s_y_mo !== 1'b0) begin bad++; $display("FAIL reset_y_mealy cyc=%0d got=%b exp=0", i, s_y_mo); end
      total++;
      if (y_ro !== 1'b0) begin bad++; $display("FAIL reset_y_moore cyc=%0d got=%b exp=0", i, y_ro); end
    end
    total++;
    if (c_mo !== 8'd0 || s_mo !== 1'b0) begin
      bad++; $display("FAIL reset_count got=%0d sat=%b exp=0 sat=0", c_mo, s_mo);
    end
    total++;
    if (c_sat !== 2'd0 || s_sat !== 1'b0) begin
      bad++; $display("FAIL reset_count_sat got=%0d sat=%b exp=0 sat=0", c_sat, s_sat);
    end
    // first match needs four fresh bits after reset
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (s_y_mo !== 1'b0) begin bad++; $display("FAIL reset_early_hit got=%b exp=0", s_y_mo); end
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (s_y_mo !== 1'b1) begin bad++; $display("FAIL reset_first_hit got=%b exp=1", s_y_mo); end
    total++;
    if (c_mo !== 8'd1) begin bad++; $display("FAIL reset_first_count got=%0d exp=1", c_mo); end
  endtask

  task automatic test_mealy_overlap_and_nonoverlap();
    logic [6:0] stream  = 7'b1101101;  // MSB first
    logic [6:0] exp_ovl = 7'b0001001;
    logic [6:0] exp_non = 7'b0001000;
    do_clear();
    for (int i = 6; i >= 0; i--) begin
      drive(1'b0, 1'b0, 1'b1, stream[i]);
      total++;
      if (s_y_mo !== exp_ovl[i]) begin
        bad++; $display("FAIL mealy_ovl_y bit=%0d got=%b exp=%b", 7 - i, s_y_mo, exp_ovl[i]);
      end
      total++;
      if (s_y_mn !== exp_non[i]) begin
        bad++; $display("FAIL mealy_nonovl_y bit=%0d got=%b exp=%b", 7 - i, s_y_mn, exp_non[i]);
      end
    end
    total++;
    if (c_mo !== 8'd2) begin bad++; $display("FAIL mealy_ovl_count got=%0d exp=2", c_mo); end
    total++;
    if (c_mn !== 8'd1) begin bad++; $display("FAIL mealy_nonovl_count got=%0d exp=1", c_mn); end
  endtask

  task automatic test_moore(input int gap);
    logic [6:0] stream = 7'b1101101;
    logic [6:0] exp_y  = 7'b0001001;
    do_clear();
    for (int i = 6; i >= 0; i--) begin
      drive(1'b0, 1'b0, 1'b1, stream[i]);
      // registered output is now showing the cycle after this bit
      total++;
      if (y_ro !== exp_y[i]) begin
        bad++; $display("FAIL moore_y gap=%0d bit=%0d got=%b exp=%b", gap, 7 - i, y_ro, exp_y[i]);
      end
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 1'b0, 1'b0, ~stream[i]);
        total++;
        if (y_ro !== 1'b0 || s_y_mo !== 1'b0) begin
          bad++; $display("FAIL moore_gap_y gap=%0d bit=%0d got=%b/%b exp=0", gap, 7 - i, y_ro, s_y_mo);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (y_ro !== 1'b0) begin bad++; $display("FAIL moore_tail_y got=%b exp=0", y_ro); end
    total++;
    if (c_ro !== 8'd2) begin bad++; $display("FAIL moore_count gap=%0d got=%0d exp=2", gap, c_ro); end
    total++;
    if (c_mo !== 8'd2) begin bad++; $display("FAIL gap_mealy_count gap=%0d got=%0d exp=2", gap, c_mo); end
  endtask

  task automatic test_saturation();
    logic [3:0] pat = 4'b1101;
    logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic       exp_sat [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_clear();
    for (int r = 0; r < 4; r++) begin
      for (int i = 3; i >= 0; i--) begin
        drive(1'b0, 1'b0, 1'b1, pat[i]);
        if (i != 0) begin
          total++;
          if (s_y_sat !== 1'b0) begin bad++; $display("FAIL sat_early_y rep=%0d got=%b exp=0", r, s_y_sat); end
        end
      end
      total++;
      if (s_y_sat !== 1'b1) begin bad++; $display("FAIL sat_y rep=%0d got=%b exp=1", r, s_y_sat); end
      total++;
      if (c_sat !== exp_cnt[r]) begin
        bad++; $display("FAIL sat_count rep=%0d got=%0d exp=%0d", r, c_sat, exp_cnt[r]);
      end
      total++;
      if (s_sat !== exp_sat[r]) begin
        bad++; $display("FAIL sat_flag rep=%0d got=%b exp=%b", r, s_sat, exp_sat[r]);
      end
    end
    total++;
    if (s_mo !== 1'b0) begin bad++; $display("FAIL wide_count_sat got=%b exp=0", s_mo); end
  endtask

  task automatic test_mid_abort(input logic use_clear);
    logic [3:0] pat = 4'b1101;
    do_clear();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    // the bit presented alongside reset/clear must be discarded
    drive(~use_clear, use_clear, 1'b1, 1'b1);
    total++;
    if (s_y_mo !== 1'b0) begin bad++; $display("FAIL abort_during_y clr=%b got=%b exp=0", use_clear, s_y_mo); end
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    total++;
    if (s_y_mo !== 1'b0) begin bad++; $display("FAIL abort_resume_y clr=%b got=%b exp=0", use_clear, s_y_mo); end
    for (int i = 3; i >= 0; i--) begin
      drive(1'b0, 1'b0, 1'b1, pat[i]);
      total++;
      if (s_y_mo !== (i == 0)) begin
        bad++; $display("FAIL abort_rematch_y clr=%b bit=%0d got=%b exp=%b", use_clear, 4 - i, s_y_mo, (i == 0));
      end
    end
    total++;
    if (c_mo !== 8'd1) begin bad++; $display("FAIL abort_count clr=%b got=%0d exp=1", use_clear, c_mo); end
  endtask

  initial begin
    test_reset();
    test_mealy_overlap_and_nonoverlap();
    test_moore(0);
    test_moore(2);
    test_saturation();
    test_mid_abort(1'b0);
    test_mid_abort(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
